// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_pkg;

    // Memory-wait sequencer states.
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StAbort   = 2'd2
    } hz_state_e;

    typedef logic [4:0] reg_idx_t;

    // x0 is hardwired to zero, so it never carries a dependency.
    localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_match.sv
// Compares the decode-stage source operands against one later-stage destination.
module hazard_match
    import hazard_pkg::*;
(
    input  reg_idx_t rs1_i,
    input  reg_idx_t rs2_i,
    input  logic     rs1_use_i,
    input  logic     rs2_use_i,
    input  reg_idx_t rd_i,
    input  logic     we_i,
    output logic     hit_o
);

    // A hit needs a real (non-x0) write that feeds an operand actually read.
    always_comb begin
        hit_o = we_i && (rd_i != REG_ZERO) &&
                ((rs1_use_i && (rs1_i == rd_i)) || (rs2_use_i && (rs2_i == rd_i)));
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables/flushes, memory-wait FSM
// with timeout, and a saturating stall-cycle counter.
// Build option: HAZARD_FWD_EN -- forwarding present, only load-use stalls.
// Without it any RAW dependency on EX or MEM stalls.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  reg_idx_t         rs1_D,
    input  reg_idx_t         rs2_D,
    input  logic             rs1_use_D,
    input  logic             rs2_use_D,
    input  reg_idx_t         rd_E,
    input  logic             regwrite_E,
    input  logic             memread_E,
    input  reg_idx_t         rd_M,
    input  logic             regwrite_M,
    input  logic             branch_taken_E,
    input  logic             mem_req_M,
    input  logic             mem_ready_M,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    hz_state_e        state_q, state_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic hit_e, hit_m;
    logic freeze, stall;

    hazard_match u_match_e (
        .rs1_i     (rs1_D),
        .rs2_i     (rs2_D),
        .rs1_use_i (rs1_use_D),
        .rs2_use_i (rs2_use_D),
        .rd_i      (rd_E),
        .we_i      (regwrite_E),
        .hit_o     (hit_e)
    );

    hazard_match u_match_m (
        .rs1_i     (rs1_D),
        .rs2_i     (rs2_D),
        .rs1_use_i (rs1_use_D),
        .rs2_use_i (rs2_use_D),
        .rd_i      (rd_M),
        .we_i      (regwrite_M),
        .hit_o     (hit_m)
    );

    // Decode-stage stall request and memory freeze condition.
    always_comb begin
        freeze = mem_req_M && !mem_ready_M;
`ifdef HAZARD_FWD_EN
        stall  = hit_e && memread_E;
`else
        // Regfile writes before reads, so WB needs no check.
        stall  = hit_e || hit_m;
`endif
    end

    // Memory-wait sequencing; wait_cnt counts consecutive frozen cycles.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun, StMemWait: begin
                if (freeze) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d    = StAbort;
                        wait_cnt_d = '0;
                    end else begin
                        state_d    = StMemWait;
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end else begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end
            end
            StAbort: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Stage controls, priority: reset, abort, freeze, redirect, stall.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_en    = 1'b1;
        mem_wb_flush = 1'b0;
        mem_err      = 1'b0;
        if (!rst_n) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (state_q == StAbort) begin
            mem_err      = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (branch_taken_E) begin
            // Instruction in ID is wrong-path, so any stall it asks for is moot.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    // Saturating count of cycles with the PC held.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        stall_cycles = stall_cycles_q;
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StRun;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule
